// File: rtl/redline_arbiter.sv
// Round-robin arbiter sharing one redline lookup unit between NREQ region checkers.
// A grant drives the unit, waits RL_LAT cycles, then returns the result with a one-cycle ack.
module redline_arbiter #(
  parameter int NREQ   = 4,
  parameter int RL_LAT = 2,
  parameter int GW     = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              clear,
  input  logic [NREQ-1:0]   req,
  input  logic [10*NREQ-1:0] req_x,
  input  logic [10*NREQ-1:0] req_y,
  input  logic [NREQ-1:0]   req_dir,
  output logic [NREQ-1:0]   ack,
  output logic              resp_exist,
  output logic [9:0]        resp_value,
  output logic [9:0]        redline_x_ball,
  output logic [9:0]        redline_y_ball,
  output logic              redline_dir,
  input  logic              redline_exist,
  input  logic [9:0]        redline_value,
  output logic              busy,
  output logic [GW-1:0]     gnt_id
);

  // state | meaning
  // IDLE  | pick next requester round-robin, latch its ball position and direction
  // WAIT  | redline inputs held; down-counter runs to terminal count, then result captured
  // ACK   | one-cycle ack to the granted requester, rotate priority
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  localparam int CW = (RL_LAT > 1) ? $clog2(RL_LAT) : 1;
  localparam logic [CW-1:0] CNT_LOAD  = CW'(RL_LAT - 1);
  localparam logic [GW-1:0] LAST_INIT = GW'(NREQ - 1);

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic [GW-1:0] last_grant;

  logic          pick_valid;
  logic [GW-1:0] pick_idx;
  logic [GW-1:0] scan_idx;

  logic [9:0] x_arr [NREQ];
  logic [9:0] y_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign x_arr[i] = req_x[10*i +: 10];
    assign y_arr[i] = req_y[10*i +: 10];
  end

  // Scan from the farthest candidate down to last_grant+1 so the nearest one wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    scan_idx   = '0;
    for (int k = NREQ; k >= 1; k--) begin
      scan_idx = GW'((int'(last_grant) + k) % NREQ);
      if (req[scan_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state          <= S_IDLE;
      wait_cnt       <= '0;
      last_grant     <= LAST_INIT;
      ack            <= '0;
      resp_exist     <= 1'b0;
      resp_value     <= '0;
      redline_x_ball <= '0;
      redline_y_ball <= '0;
      redline_dir    <= 1'b0;
      gnt_id         <= '0;
    end else begin
      ack <= '0;
      case (state)
        S_IDLE: begin
          if (pick_valid) begin
            redline_x_ball <= x_arr[pick_idx];
            redline_y_ball <= y_arr[pick_idx];
            redline_dir    <= req_dir[pick_idx];
            gnt_id         <= pick_idx;
            wait_cnt       <= CNT_LOAD;
            state          <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (wait_cnt == '0) begin
            resp_exist   <= redline_exist;
            resp_value   <= redline_value;
            ack[gnt_id]  <= 1'b1;
            state        <= S_ACK;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        S_ACK: begin
          last_grant <= gnt_id;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_redline_arbiter.sv
// Directed bench for redline_arbiter with a latency-aware redline unit model and result scoreboard.
module tb_redline_arbiter;
  localparam int NREQ   = 4;
  localparam int RL_LAT = 2;
  localparam int GW     = 2;

  logic            clk = 1'b0;
  logic            clear;
  logic [3:0]      req;
  logic [39:0]     req_x, req_y;
  logic [3:0]      req_dir;
  logic [3:0]      ack;
  logic            resp_exist;
  logic [9:0]      resp_value;
  logic [9:0]      redline_x_ball, redline_y_ball;
  logic            redline_dir;
  logic            redline_exist;
  logic [9:0]      redline_value;
  logic            busy;
  logic [GW-1:0]   gnt_id;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int         id;
    logic       ex;
    logic [9:0] val;
  } exp_t;
  exp_t sb[$];

  redline_arbiter #(.NREQ(NREQ), .RL_LAT(RL_LAT), .GW(GW)) dut (
    .clk(clk), .clear(clear), .req(req), .req_x(req_x), .req_y(req_y), .req_dir(req_dir),
    .ack(ack), .resp_exist(resp_exist), .resp_value(resp_value),
    .redline_x_ball(redline_x_ball), .redline_y_ball(redline_y_ball), .redline_dir(redline_dir),
    .redline_exist(redline_exist), .redline_value(redline_value),
    .busy(busy), .gnt_id(gnt_id)
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] rl_model(input logic [9:0] x, input logic [9:0] y, input logic d);
    logic [9:0] c;
    c = d ? x : y;
    return {(c < 10'd900), (d ? x + 10'd50 : y + 10'd7)};
  endfunction

  // Redline unit: result is only correct once its inputs have been stable for two cycles.
  logic [20:0] rl_cur, rl_last;
  logic [10:0] rl_res;
  assign rl_cur = {redline_dir, redline_y_ball, redline_x_ball};
  assign rl_res = rl_model(redline_x_ball, redline_y_ball, redline_dir);
  always @(posedge clk) rl_last <= rl_cur;
  assign redline_exist = (rl_cur === rl_last) ? rl_res[10]  : ~rl_res[10];
  assign redline_value = (rl_cur === rl_last) ? rl_res[9:0] : (rl_res[9:0] ^ 10'h2AA);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [9:0] x, input logic [9:0] y, input logic d);
    req_x[10*i +: 10] = x;
    req_y[10*i +: 10] = y;
    req_dir[i]        = d;
  endtask

  task automatic push_exp(input int i);
    logic [10:0] m;
    exp_t e;
    m = rl_model(req_x[10*i +: 10], req_y[10*i +: 10], req_dir[i]);
    e.id  = i;
    e.ex  = m[10];
    e.val = m[9:0];
    sb.push_back(e);
  endtask

  task automatic wait_ack(output int n);
    exp_t e;
    logic [3:0] onehot;
    n = 0;
    do begin
      cyc();
      n++;
    end while (ack == 4'b0 && n < 20);
    tests++;
    assert (ack != 4'b0 && sb.size() > 0) else begin
      fails++;
      $error("FAIL ack_wait: observed ack %0h queue %0d after %0d cycles, expected an ack", ack, sb.size(), n);
      return;
    end
    e = sb.pop_front();
    onehot = 4'b0001 << e.id;
    chk("ack_vec",    32'(ack),        32'(onehot));
    chk("gnt_id",     32'(gnt_id),     32'(e.id));
    chk("resp_exist", 32'(resp_exist), 32'(e.ex));
    chk("resp_value", 32'(resp_value), 32'(e.val));
    req[e.id] = 1'b0;
  endtask

  logic [3:0] prev_ack = 4'b0;
  always @(negedge clk) begin
    if (ack != 4'b0) begin
      chk("ack_onehot",  32'($onehot(ack)), 32'd1);
      chk("ack_spacing", 32'(prev_ack),     32'd0);
    end
    prev_ack = ack;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    clear   = 1'b1;
    req     = 4'b1111;
    req_x   = {$urandom, $urandom};
    req_y   = {$urandom, $urandom};
    req_dir = 4'($urandom);

    for (int c = 0; c < 3; c++) begin
      cyc();
      chk("rst_ack",  32'(ack),            32'd0);
      chk("rst_busy", 32'(busy),           32'd0);
      chk("rst_rlx",  32'(redline_x_ball), 32'd0);
      chk("rst_resp", 32'(resp_value),     32'd0);
      chk("rst_gnt",  32'(gnt_id),         32'd0);
    end
    chk("rst_rly",  32'(redline_y_ball), 32'd0);
    chk("rst_rld",  32'(redline_dir),    32'd0);
    chk("rst_rex",  32'(resp_exist),     32'd0);
    req   = 4'b0;
    clear = 1'b0;
    cyc();
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_ack",  32'(ack),  32'd0);

    // Single request from requester 0
    set_req(0, 10'd100, 10'd200, 1'b1);
    req = 4'b0001;
    push_exp(0);
    cyc();
    chk("single_rlx",  32'(redline_x_ball), 32'd100);
    chk("single_rly",  32'(redline_y_ball), 32'd200);
    chk("single_rld",  32'(redline_dir),    32'd1);
    chk("single_busy", 32'(busy),           32'd1);
    wait_ack(n);
    chk("single_lat",    32'(n),          32'd2);
    chk("single_value",  32'(resp_value), 32'd150);
    chk("single_exist",  32'(resp_exist), 32'd1);
    cyc();
    chk("single_idle_busy", 32'(busy), 32'd0);
    chk("single_idle_ack",  32'(ack),  32'd0);
    chk("single_hold_val",  32'(resp_value), 32'd150);

    // Fresh priority, then everyone requesting
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, 10'(300 + 17*i), 10'(40 + 33*i), 1'(i));
    req = 4'b1111;
    for (int k = 0; k < 5; k++) push_exp(k % 4);
    for (int k = 0; k < 5; k++) begin
      wait_ack(n);
      chk("all_spacing", 32'(n), 32'd3);
      if (k < 4) begin
        cyc();
        req[k % 4] = 1'b1;
      end
    end
    cyc();
    req = 4'b0;

    // Rotation: grant 2, then 0101 gives 0 before 2
    set_req(2, 10'd1023, 10'd5, 1'b1);
    req = 4'b0100;
    push_exp(2);
    wait_ack(n);
    chk("rot_first_lat", 32'(n), 32'd3);
    cyc();
    set_req(0, 10'd12, 10'd900, 1'b0);
    req = 4'b0101;
    push_exp(0);
    push_exp(2);
    wait_ack(n);
    cyc();
    wait_ack(n);
    chk("rot_second_lat", 32'(n), 32'd3);
    cyc();
    req = 4'b0;

    // Clear during WAIT of a grant to requester 1
    set_req(1, 10'd333, 10'd444, 1'b1);
    req = 4'b0010;
    cyc();
    chk("mid_gnt",  32'(gnt_id), 32'd1);
    chk("mid_busy", 32'(busy),   32'd1);
    clear = 1'b1;
    #1;
    chk("mid_clr_busy", 32'(busy),           32'd0);
    chk("mid_clr_gnt",  32'(gnt_id),         32'd0);
    chk("mid_clr_rlx",  32'(redline_x_ball), 32'd0);
    set_req(0, 10'd21, 10'd610, 1'b0);
    req = 4'b0011;
    cyc();
    chk("mid_clr_ack", 32'(ack), 32'd0);
    clear = 1'b0;
    push_exp(0);
    push_exp(1);
    wait_ack(n);
    chk("mid_first_lat", 32'(n), 32'd3);
    cyc();
    wait_ack(n);
    cyc();
    req = 4'b0;

    // Request dropped after grant, inputs changed mid-transaction
    set_req(2, 10'd40, 10'd950, 1'b0);
    req = 4'b0100;
    push_exp(2);
    cyc();
    req = 4'b0;
    set_req(2, 10'd1, 10'd2, 1'b1);
    chk("drop_rlx", 32'(redline_x_ball), 32'd40);
    chk("drop_rly", 32'(redline_y_ball), 32'd950);
    chk("drop_rld", 32'(redline_dir),    32'd0);
    wait_ack(n);
    chk("drop_lat",   32'(n),          32'd2);
    chk("drop_value", 32'(resp_value), 32'd957);
    chk("drop_exist", 32'(resp_exist), 32'd0);
    cyc();
    chk("drop_idle_busy", 32'(busy), 32'd0);
    cyc();
    chk("drop_no_regrant", 32'(busy), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/redline_arbiter.md
# redline_arbiter

Shares the single redline lookup unit between NREQ region checkers, for example one per scan direction. Each checker raises a request with a ball position and direction. The arbiter grants requesters round-robin and drives the redline unit's inputs from the granted requester. After a fixed settle latency it captures the result and returns it with a one-cycle acknowledge pulse to the granted requester.

## Interface
Parameters:
- NREQ, 4: number of requesters (2..8).
- RL_LAT, 2: cycles the redline unit needs from stable inputs to a valid result (≥1).
- GW, clog2(NREQ): width of the grant index.

Ports:
- clk  in  1  system clock; all state on the rising edge.
- clear  in  1  reset, asynchronous, active-high.
- req  in  NREQ  request per requester; held high until that requester's ack.
- req_x  in  10*NREQ  ball x coordinate; requester i on bits [10i+9:10i].
- req_y  in  10*NREQ  ball y coordinate, packed the same way.
- req_dir  in  NREQ  direction per requester (1 = left/right, compare on x; 0 = up/down, compare on y).
- ack  out  NREQ  one-hot, one-cycle pulse; resp_* are valid in the same cycle.
- resp_exist  out  1  captured redline exist flag.
- resp_value  out  10  captured redline distance.
- redline_x_ball  out  10  x coordinate to the redline unit.
- redline_y_ball  out  10  y coordinate to the redline unit.
- redline_dir  out  1  direction to the redline unit.
- redline_exist  in  1  redline unit result: a line exists.
- redline_value  in  10  redline unit result: line distance.
- busy  out  1  high whenever the FSM is not in IDLE.
- gnt_id  out  GW  index of the current or last granted requester.

## Operation
- FSM states: IDLE, WAIT, ACK.
- IDLE:
  - If req is nonzero, choose the first requester with req set, searching upward from last_grant+1 modulo NREQ.
  - Latch that requester's x, y and dir into the redline_* output registers.
  - Set gnt_id to the chosen index, load wait counter = RL_LAT-1, go to WAIT.
- WAIT:
  - redline_* outputs are held constant.
  - The counter decrements each cycle.
  - When the counter is 0, capture redline_exist and redline_value into resp_*, go to ACK.
- ACK:
  - ack[gnt_id] = 1 for exactly this cycle.
  - last_grant <= gnt_id; go to IDLE.
- resp_*, redline_* and gnt_id hold their values between transactions.
- The req and req_* inputs are sampled only in IDLE. Changes during WAIT/ACK are ignored.
- If a requester drops req mid-transaction, the transaction still completes and its ack still pulses.
- Requesters must deassert req on the clock edge that samples their ack. Otherwise they are eligible again next IDLE, subject to round-robin order.
- Reset values:
  - state = IDLE.
  - last_grant = NREQ-1, so requester 0 has first priority after reset.
  - ack, resp_exist, resp_value, redline_x_ball, redline_y_ball, redline_dir, gnt_id = 0; busy = 0.
- If clear asserts mid-transaction, all state is reset immediately, no ack is issued, and the requester must re-request.
- Widths: 10-bit coordinates and values are passed through unmodified. There is no arithmetic on the data.

## Timing
- Requests are sampled in IDLE at the end of cycle 0.
- Cycles 1..RL_LAT: WAIT, with redline_* valid from cycle 1.
- Result is sampled at the end of cycle RL_LAT.
- Cycle RL_LAT+1: ACK, with ack and resp_* valid.
- Cycle RL_LAT+2: IDLE; the earliest next grant is sampled here.
- Throughput: one lookup per RL_LAT+2 cycles (4 cycles at the defaults).
- busy is high for cycles 1..RL_LAT+1 and derives from registered state only.
- ack is never high in two consecutive cycles, and at most one bit of ack is set.

## Test plan
- Reset: hold clear for 3 cycles with arbitrary inputs. All outputs stay 0. After release, busy = 0 and ack = 0.
- Single request: req = 0001, x = 100, y = 200, dir = 1; redline model returns exist = 1, value = 150.
  - Cycle 1: redline_x_ball = 100, redline_y_ball = 200, redline_dir = 1.
  - Cycle 3: ack = 0001, resp_exist = 1, resp_value = 150, gnt_id = 0.
- All requesting: req = 1111, each requester re-raises req after its ack.
  - Grants come in order 0, 1, 2, 3, 0 with acks every 4 cycles.
  - No requester is acknowledged twice before the others.
- Rotation: after a grant to requester 2, present req = 0101. Requester 0 is granted next, then requester 2.
- Reset mid-operation: assert clear during WAIT of a grant to requester 1.
  - No ack occurs and busy drops immediately.
  - After release with req = 0011, requester 0 is granted first.
- Dropped request: req = 0100 is deasserted in cycle 1. ack = 0100 still pulses in cycle 3, and resp_* equals the model result for the latched coordinates.
